trap_controller: RTL

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller_if.sv | 39 +++
 rtl/trap_controller.sv | 108 ++++++++++
 2 files changed

// File: rtl/trap_controller_if.sv
// Trap controller bus: core-side event/CSR inputs and trap-sequencing outputs.
// The core side uses the master modport; trap_controller uses the slave modport.
interface trap_controller_if;
    logic        exception_i;
    logic [4:0]  exception_code_i;
    logic [31:0] exc_pc_i;
    logic [31:0] exc_tval_i;
    logic [2:0]  irq_i;
    logic [2:0]  irq_en_i;
    logic        mstatus_mie_i;
    logic        mret_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        drain_done_i;

    logic        flush_o;
    logic        csr_we_o;
    logic [31:0] mepc_o;
    logic [31:0] mcause_o;
    logic [31:0] mtval_o;
    logic        mstatus_ret_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    modport master (
        output exception_i, exception_code_i, exc_pc_i, exc_tval_i,
        output irq_i, irq_en_i, mstatus_mie_i, mret_i, mtvec_i, mepc_i, drain_done_i,
        input  flush_o, csr_we_o, mepc_o, mcause_o, mtval_o,
        input  mstatus_ret_o, redirect_o, redirect_pc_o, busy_o
    );

    modport slave (
        input  exception_i, exception_code_i, exc_pc_i, exc_tval_i,
        input  irq_i, irq_en_i, mstatus_mie_i, mret_i, mtvec_i, mepc_i, drain_done_i,
        output flush_o, csr_we_o, mepc_o, mcause_o, mtval_o,
        output mstatus_ret_o, redirect_o, redirect_pc_o, busy_o
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: exception/interrupt/MRET -> flush -> CSR write -> redirect.
// Define VECTORED_MODE_EN to vector interrupts to base+4*cause when mtvec mode is 01.
module trap_controller (
    input  logic              clk,
    input  logic              reset,
    trap_controller_if.slave  bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FLUSH    = 2'd1;
    localparam logic [1:0] CSR_WR   = 2'd2;
    localparam logic [1:0] REDIRECT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        is_mret_q;
    logic [31:0] mepc_q, mcause_q, mtval_q, redirect_pc_q;

    logic [2:0]  irq_pending;
    logic        irq_take;
    logic [4:0]  irq_cause;
    logic [31:0] trap_base;
    logic [31:0] irq_target;

    assign irq_pending = bus.irq_i & bus.irq_en_i;
    assign irq_take    = (|irq_pending) && bus.mstatus_mie_i;
    assign trap_base   = {bus.mtvec_i[31:2], 2'b00};

    // Fixed priority: external (11) > software (3) > timer (7).
    always_comb begin
        // NOTE: default first so every path assigns irq_cause and no latch is inferred.
        irq_cause = 5'd7;
        if (irq_pending[2])
            irq_cause = 5'd11;
        else if (irq_pending[0])
            irq_cause = 5'd3;
    end

`ifdef VECTORED_MODE_EN
    assign irq_target = (bus.mtvec_i[1:0] == 2'b01)
                        ? trap_base + {25'd0, irq_cause, 2'b00}
                        : trap_base;
`else
    logic unused_mode_bits;
    assign unused_mode_bits = ^bus.mtvec_i[1:0];
    assign irq_target       = trap_base;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.exception_i || irq_take)
                    state_d = FLUSH;
                else if (bus.mret_i)
                    state_d = REDIRECT;
            end
            FLUSH:    if (bus.drain_done_i) state_d = CSR_WR;
            CSR_WR:   state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Events are only sampled in IDLE; the latched data then stays put until the next trap.
    always_ff @(posedge clk) begin
        // NOTE: the CSR data registers are reset too, so a reset leaves every output at 0.
        if (reset) begin
            state_q       <= IDLE;
            is_mret_q     <= 1'b0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            redirect_pc_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates in this edge consistent.
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (bus.exception_i) begin
                    mepc_q        <= bus.exc_pc_i;
                    mcause_q      <= {1'b0, 26'd0, bus.exception_code_i};
                    mtval_q       <= bus.exc_tval_i;
                    redirect_pc_q <= trap_base;
                    is_mret_q     <= 1'b0;
                end else if (irq_take) begin
                    mepc_q        <= bus.exc_pc_i;
                    mcause_q      <= {1'b1, 26'd0, irq_cause};
                    mtval_q       <= '0;
                    redirect_pc_q <= irq_target;
                    is_mret_q     <= 1'b0;
                end else if (bus.mret_i) begin
                    redirect_pc_q <= bus.mepc_i;
                    is_mret_q     <= 1'b1;
                end
            end
        end
    end

    assign bus.flush_o       = (state_q == FLUSH);
    assign bus.csr_we_o      = (state_q == CSR_WR);
    assign bus.redirect_o    = (state_q == REDIRECT);
    assign bus.mstatus_ret_o = (state_q == REDIRECT) && is_mret_q;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.mepc_o        = mepc_q;
    assign bus.mcause_o      = mcause_q;
    assign bus.mtval_o       = mtval_q;
    assign bus.redirect_pc_o = redirect_pc_q;

endmodule
